// File: rtl/shift_reg_iter.sv
// shift_reg_iter: loadable bidirectional shift register with a built-in
// iteration counter for the iterative divider datapath.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous reset, active-low
//   D        parallel load data
//   s_L      1 = load D, 0 = shift (both qualified by E)
//   E        enable; nothing changes while low
//   dir      0 = shift toward MSB, 1 = shift toward LSB
//   mode     00 logical, 01 rotate, 10 arithmetic, 11 logical
//   w        serial-in bit for logical shifts
//   Q        register contents
//   so       bit shifted out by the last accepted shift
//   count    accepted shifts since the last load
//   busy     loaded with shifts remaining
//   done     level, set after ITER shifts; cleared by load or reset
module shift_reg_iter #(
  parameter int unsigned  WIDTH = 6,
  parameter int unsigned  ITER  = 6,
  localparam int unsigned CNT_W = $clog2(ITER + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] D,
  input  logic             s_L,
  input  logic             E,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             w,
  output logic [WIDTH-1:0] Q,
  output logic             so,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_ARITH = 2'b10;

  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fill_bit;

  // Next-state: load beats shift; shifts only count while busy.
  always_comb begin
    q_d      = q_q;
    so_d     = so_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = done_q;
    fill_bit = w;

    if (E) begin
      if (s_L) begin
        q_d     = D;
        count_d = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
      end else if (busy_q) begin
        if (!dir) begin
          // Arithmetic left is identical to logical left.
          fill_bit = (mode == MODE_ROT) ? q_q[WIDTH-1] : w;
          so_d     = q_q[WIDTH-1];
          q_d      = {q_q[WIDTH-2:0], fill_bit};
        end else begin
          case (mode)
            MODE_ROT:   fill_bit = q_q[0];
            MODE_ARITH: fill_bit = q_q[WIDTH-1];
            default:    fill_bit = w;
          endcase
          so_d = q_q[0];
          q_d  = {fill_bit, q_q[WIDTH-1:1]};
        end
        count_d = count_q + CNT_W'(1);
        // Last shift of the operation retires busy and raises done together.
        if (count_q == CNT_W'(ITER - 1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q     <= '0;
      so_q    <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      so_q    <= so_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_q;
  assign so    = so_q;
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_shift_reg_iter.sv
// Self-checking bench for shift_reg_iter: directed scenarios plus a
// randomised back-to-back run against a small reference model.
module tb_shift_reg_iter;

  localparam int unsigned WIDTH = 6;
  localparam int unsigned ITER  = 6;
  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             so;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;
  } obs_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] D;
  logic             s_L;
  logic             E;
  logic             dir;
  logic [1:0]       mode;
  logic             w;
  logic [WIDTH-1:0] Q;
  logic             so;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;

  obs_t sb[$];
  obs_t cur;
  obs_t exp_o;
  obs_t got;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shift_reg_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk(clk), .reset_n(reset_n), .D(D), .s_L(s_L), .E(E), .dir(dir),
    .mode(mode), .w(w), .Q(Q), .so(so), .count(count), .busy(busy), .done(done)
  );

  function automatic obs_t mk(logic [WIDTH-1:0] q, logic s, logic [CNT_W-1:0] c,
                              logic b, logic dn);
    obs_t o;
    o.q = q; o.so = s; o.cnt = c; o.busy = b; o.done = dn;
    return o;
  endfunction

  function automatic obs_t sample();
    return {Q, so, count, busy, done};
  endfunction

  // Reference behaviour, written from the operation table.
  function automatic obs_t model(obs_t s, logic rst, logic e, logic sl, logic [WIDTH-1:0] d,
                                 logic dr, logic [1:0] md, logic wi);
    obs_t n = s;
    if (!rst) return mk('0, 1'b0, '0, 1'b0, 1'b0);
    if (e && sl) begin
      n.q = d; n.cnt = '0; n.busy = 1'b1; n.done = 1'b0;
    end else if (e && s.busy) begin
      if (!dr) begin
        n.so = s.q[5];
        n.q  = (md == 2'b01) ? {s.q[4:0], s.q[5]} : {s.q[4:0], wi};
      end else begin
        n.so = s.q[0];
        if (md == 2'b01)      n.q = {s.q[0], s.q[5:1]};
        else if (md == 2'b10) n.q = {s.q[5], s.q[5:1]};
        else                  n.q = {wi, s.q[5:1]};
      end
      n.cnt = s.cnt + 3'd1;
      if (n.cnt == 3'(ITER)) begin
        n.busy = 1'b0; n.done = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic apply(input logic rst, input logic e, input logic sl, input logic [WIDTH-1:0] d,
                       input logic dr, input logic [1:0] md, input logic wi);
    reset_n = rst; E = e; s_L = sl; D = d; dir = dr; mode = md; w = wi;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(6'b000000, 1'b0, 3'd0, 1'b0, 1'b0));
      apply(1'b0, 1'b1, 1'b1, 6'h3F, 1'b0, 2'b00, 1'b1);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL reset edge %0d: got %p expected %p", i, got, exp_o);
      end
      cur = exp_o;
    end
  endtask

  task automatic test_left_logical();
    logic [WIDTH-1:0] qs [8] = '{6'b101101, 6'b011011, 6'b110111, 6'b101111,
                                 6'b011111, 6'b111111, 6'b111111, 6'b111111};
    logic             ss [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [CNT_W-1:0] cs [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
    for (int i = 0; i < 8; i++) begin
      sb.push_back(mk(qs[i], ss[i], cs[i], i < 6, i >= 6));
      apply(1'b1, 1'b1, i == 0, 6'b101101, 1'b0, 2'b00, 1'b1);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL left_logical step %0d: got %p expected %p", i, got, exp_o);
      end
      cur = exp_o;
    end
  endtask

  task automatic test_right_rotate();
    logic [WIDTH-1:0] qs [4] = '{6'b100001, 6'b110000, 6'b011000, 6'b001100};
    logic             ss [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(qs[i], ss[i], 3'(i), 1'b1, 1'b0));
      apply(1'b1, 1'b1, i == 0, 6'b100001, 1'b1, 2'b01, 1'b0);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL right_rotate step %0d: got %p expected %p", i, got, exp_o);
      end
      cur = exp_o;
    end
  endtask

  task automatic test_right_arith();
    logic [WIDTH-1:0] qs [3] = '{6'b100100, 6'b110010, 6'b111001};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(qs[i], 1'b0, 3'(i), 1'b1, 1'b0));
      apply(1'b1, 1'b1, i == 0, 6'b100100, 1'b1, 2'b10, 1'b0);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL right_arith step %0d: got %p expected %p", i, got, exp_o);
      end
      cur = exp_o;
    end
  endtask

  // Third shift, an E=0 hold with load requested, then a mid-operation reload.
  task automatic test_reload();
    logic             es [3] = '{1'b1, 1'b0, 1'b1};
    logic             ls [3] = '{1'b0, 1'b1, 1'b1};
    logic [WIDTH-1:0] ds [3] = '{6'b000000, 6'b000000, 6'b010101};
    obs_t             ex [3];
    ex[0] = mk(6'b111100, 1'b1, 3'd3, 1'b1, 1'b0);
    ex[1] = mk(6'b111100, 1'b1, 3'd3, 1'b1, 1'b0);
    ex[2] = mk(6'b010101, 1'b1, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex[i]);
      apply(1'b1, es[i], ls[i], ds[i], 1'b1, 2'b10, 1'b0);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL reload step %0d: got %p expected %p", i, got, exp_o);
      end
      cur = exp_o;
    end
  endtask

  // One left shift, then reset while a shift is requested, then an ignored shift.
  task automatic test_reset_mid();
    logic rs [3] = '{1'b1, 1'b0, 1'b1};
    obs_t ex [3];
    ex[0] = mk(6'b101010, 1'b0, 3'd1, 1'b1, 1'b0);
    ex[1] = mk(6'b000000, 1'b0, 3'd0, 1'b0, 1'b0);
    ex[2] = mk(6'b000000, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex[i]);
      apply(rs[i], 1'b1, 1'b0, 6'b111111, 1'b0, 2'b00, 1'b0);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL reset_mid step %0d: got %p expected %p", i, got, exp_o);
      end
      cur = exp_o;
    end
  endtask

  // Random per-cycle dir/mode/w/E with occasional loads and resets.
  task automatic test_back_to_back();
    logic             rst, e, sl, dr, wi;
    logic [1:0]       md;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 80; i++) begin
      rst = ($urandom_range(0, 39) != 0);
      e   = (i == 0) || ($urandom_range(0, 3) != 0);
      sl  = (i == 0) || ($urandom_range(0, 9) == 0);
      d   = WIDTH'($urandom);
      dr  = 1'($urandom);
      md  = 2'($urandom);
      wi  = 1'($urandom);
      sb.push_back(model(cur, rst, e, sl, d, dr, md, wi));
      apply(rst, e, sl, d, dr, md, wi);
      exp_o = sb.pop_front(); got = sample(); n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL back_to_back cycle %0d: got %p expected %p", i, got, exp_o);
      end
      cur = exp_o;
    end
  endtask

  initial begin
    reset_n = 1'b0; E = 1'b0; s_L = 1'b0; D = '0; dir = 1'b0; mode = 2'b00; w = 1'b0;
    test_reset();
    test_left_logical();
    test_right_rotate();
    test_right_arith();
    test_reload();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
